// File: rtl/dma_pkg.sv
// Shared definitions for the DMA command sequencer: register map, op codes,
// status bits and the FSM/bus-request types used by the top and its bus master.
package dma_pkg;

   localparam logic [2:0] OFF_OP   = 3'd0;
   localparam logic [2:0] OFF_WCNT = 3'd1;
   localparam logic [2:0] OFF_LAD  = 3'd2;
   localparam logic [2:0] OFF_HLO  = 3'd3;
   localparam logic [2:0] OFF_HHI  = 3'd4;
   localparam logic [2:0] OFF_WAIT = 3'd5;

   localparam logic [3:0] OP_TX = 4'hA;
   localparam logic [3:0] OP_RX = 4'h5;

   localparam int ST_IOC = 7;
   localparam int ST_NXM = 6;

   typedef enum logic [3:0] {
      S_IDLE, S_W_WCNT, S_W_LAD, S_W_HLO, S_W_HHI, S_W_WAIT, S_W_OP, S_POLL, S_CLR, S_DONE
   } seq_state_t;

   typedef enum logic [1:0] {X_IDLE, X_BUS, X_GAP} xfer_state_t;

   typedef struct packed {
      logic        we;
      logic [2:0]  adr;
      logic [15:0] dat;
   } bus_req_t;

   function automatic logic [15:0] op_word(input logic dir);
      return {12'h000, (dir ? OP_RX : OP_TX)};
   endfunction

endpackage

// File: rtl/wbm_xfer.sv
// Single-transaction Wishbone master: latches a request, holds cyc/stb until ack,
// then keeps the bus idle for exactly GAP cycles before the next strobe may start.
module wbm_xfer
   import dma_pkg::*;
#(
   parameter int GAP = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        we_i,
   input  logic [2:0]  adr_i,
   input  logic [15:0] dat_i,
   output logic        done_o,
   output logic [15:0] rdata_o,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [2:0]  wbm_adr_o,
   output logic [15:0] wbm_dat_o,
   input  logic [15:0] wbm_dat_i,
   input  logic        wbm_ack_i
);

   localparam int GW = (GAP < 2) ? 1 : $clog2(GAP + 1);

   xfer_state_t    state_reg, state_next;
   logic [GW-1:0]  gap_cnt_reg;
   logic           done_reg;
   logic [15:0]    rdata_reg;
   logic           we_reg;
   logic [2:0]     adr_reg;
   logic [15:0]    dat_reg;
   logic           acked;
   logic           launch;

   assign acked  = (state_reg == X_BUS) && wbm_ack_i;
   assign launch = (state_next == X_BUS) && (state_reg != X_BUS);

   always_ff @(posedge clk_i) begin
      if (rst_i) state_reg <= X_IDLE;
      else       state_reg <= state_next;
   end

   // The last gap cycle may launch directly so the idle run is exactly GAP long.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         X_IDLE:  if (start_i) state_next = X_BUS;
         X_BUS:   if (wbm_ack_i) state_next = X_GAP;
         X_GAP:   if (gap_cnt_reg == GW'(1)) state_next = start_i ? X_BUS : X_IDLE;
         default: state_next = X_IDLE;
      endcase
   end

   always_comb begin
      wbm_cyc_o = (state_reg == X_BUS);
      wbm_stb_o = (state_reg == X_BUS);
      wbm_we_o  = we_reg;
      wbm_adr_o = adr_reg;
      wbm_dat_o = dat_reg;
      done_o    = done_reg;
      rdata_o   = rdata_reg;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         gap_cnt_reg <= '0;
         done_reg    <= 1'b0;
         rdata_reg   <= 16'h0000;
         we_reg      <= 1'b0;
         adr_reg     <= 3'd0;
         dat_reg     <= 16'h0000;
      end else begin
         done_reg <= acked;
         if (acked) begin
            rdata_reg   <= wbm_dat_i;
            gap_cnt_reg <= GW'(GAP);
         end else if (state_reg == X_GAP) begin
            gap_cnt_reg <= gap_cnt_reg - GW'(1);
         end
         if (launch) begin
            we_reg  <= we_i;
            adr_reg <= adr_i;
            dat_reg <= dat_i;
         end
      end
   end

endmodule

// File: rtl/dma_cmd_seq.sv
// Command sequencer in front of the DMA block: programs the DMA registers for one
// buffer transfer, starts it, polls for completion, clears the op register and reports.
module dma_cmd_seq
   import dma_pkg::*;
#(
   parameter logic [5:0]  IBUS_WAIT  = 6'd63,
   parameter logic [15:0] POLL_LIMIT = 16'd4095,
   parameter int          GAP        = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic        cmd_dir_i,
   input  logic [20:0] cmd_haddr_i,
   input  logic [14:0] cmd_lad_i,
   input  logic [15:0] cmd_words_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        done_nxm_o,
   output logic        done_tmo_o,
   output logic [2:0]  wbm_adr_o,
   output logic [15:0] wbm_dat_o,
   input  logic [15:0] wbm_dat_i,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [1:0]  wbm_sel_o,
   input  logic        wbm_ack_i
);

   seq_state_t  state_reg, state_next;
   logic        dir_reg;
   logic [20:0] haddr_reg;
   logic [14:0] lad_reg;
   logic [15:0] words_reg;
   logic [15:0] poll_cnt_reg;
   logic        nxm_reg, tmo_reg;
   logic        x_done;
   logic [15:0] x_rdata;
   logic        req;
   bus_req_t    bus_req;
   logic        accept, ioc, poll_last;

   assign accept    = (state_reg == S_IDLE) && cmd_valid_i;
   assign ioc       = x_rdata[ST_IOC];
   assign poll_last = (poll_cnt_reg == POLL_LIMIT - 16'd1);
   assign wbm_sel_o = 2'b11;

   always_ff @(posedge clk_i) begin
      if (rst_i) state_reg <= S_IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:   if (cmd_valid_i) state_next = S_W_WCNT;
         S_W_WCNT: if (words_reg == 16'd0) state_next = S_DONE;
                   else if (x_done)        state_next = S_W_LAD;
         S_W_LAD:  if (x_done) state_next = S_W_HLO;
         S_W_HLO:  if (x_done) state_next = S_W_HHI;
         S_W_HHI:  if (x_done) state_next = S_W_WAIT;
         S_W_WAIT: if (x_done) state_next = S_W_OP;
         S_W_OP:   if (x_done) state_next = S_POLL;
         S_POLL:   if (x_done && (ioc || poll_last)) state_next = S_CLR;
         S_CLR:    if (x_done) state_next = S_DONE;
         S_DONE:   state_next = S_IDLE;
         default:  state_next = S_IDLE;
      endcase
   end

   always_comb begin
      cmd_ready_o = (state_reg == S_IDLE);
      busy_o      = (state_reg != S_IDLE);
      done_o      = (state_reg == S_DONE);
      done_nxm_o  = (state_reg == S_DONE) && nxm_reg;
      done_tmo_o  = (state_reg == S_DONE) && tmo_reg;
      req         = 1'b1;
      bus_req     = '{we: 1'b1, adr: OFF_OP, dat: 16'h0000};
      case (state_reg)
         S_W_WCNT: begin
            req         = (words_reg != 16'd0);
            bus_req.adr = OFF_WCNT;
            bus_req.dat = ~words_reg + 16'd1;
         end
         S_W_LAD:  begin bus_req.adr = OFF_LAD;  bus_req.dat = {lad_reg, 1'b0};          end
         S_W_HLO:  begin bus_req.adr = OFF_HLO;  bus_req.dat = {haddr_reg[14:0], 1'b0};  end
         S_W_HHI:  begin bus_req.adr = OFF_HHI;  bus_req.dat = {10'b0, haddr_reg[20:15]}; end
         S_W_WAIT: begin bus_req.adr = OFF_WAIT; bus_req.dat = {10'b0, IBUS_WAIT};       end
         S_W_OP:   bus_req.dat = op_word(dir_reg);
         S_POLL:   bus_req.we = 1'b0;
         S_CLR:    ;
         default:  req = 1'b0;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         dir_reg      <= 1'b0;
         haddr_reg    <= 21'd0;
         lad_reg      <= 15'd0;
         words_reg    <= 16'd0;
         poll_cnt_reg <= 16'd0;
         nxm_reg      <= 1'b0;
         tmo_reg      <= 1'b0;
      end else if (accept) begin
         dir_reg      <= cmd_dir_i;
         haddr_reg    <= cmd_haddr_i;
         lad_reg      <= cmd_lad_i;
         words_reg    <= cmd_words_i;
         poll_cnt_reg <= 16'd0;
         nxm_reg      <= 1'b0;
         tmo_reg      <= 1'b0;
      end else if ((state_reg == S_POLL) && x_done) begin
         if (ioc) begin
            nxm_reg <= x_rdata[ST_NXM];
         end else begin
            poll_cnt_reg <= poll_cnt_reg + 16'd1;
            if (poll_last) tmo_reg <= 1'b1;
         end
      end
   end

   // A request is masked during the done pulse so the finished transfer is not relaunched.
   wbm_xfer #(.GAP(GAP)) u_xfer (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .start_i   (req && !x_done),
      .we_i      (bus_req.we),
      .adr_i     (bus_req.adr),
      .dat_i     (bus_req.dat),
      .done_o    (x_done),
      .rdata_o   (x_rdata),
      .wbm_cyc_o (wbm_cyc_o),
      .wbm_stb_o (wbm_stb_o),
      .wbm_we_o  (wbm_we_o),
      .wbm_adr_o (wbm_adr_o),
      .wbm_dat_o (wbm_dat_o),
      .wbm_dat_i (wbm_dat_i),
      .wbm_ack_i (wbm_ack_i)
   );

endmodule
